// File: rtl/vga_cmd_pkg.sv
// Shared definitions for the VGA command controller: opcodes, response
// codes, pattern encodings, parser states and the colour record.
package vga_cmd_pkg;

  localparam logic [7:0] OP_PATTERN = 8'h50;  // 'P'
  localparam logic [7:0] OP_COLOUR  = 8'h43;  // 'C'
  localparam logic [7:0] RSP_ACK    = 8'h06;
  localparam logic [7:0] RSP_NAK    = 8'h15;

  typedef enum logic [2:0] {
    PAT_SOLID   = 3'd0,
    PAT_BARS    = 3'd1,
    PAT_CHECKER = 3'd2,
    PAT_HGRAD   = 3'd3,
    PAT_VGRAD   = 3'd4,
    PAT_BORDER  = 3'd5,
    PAT_BLACK6  = 3'd6,
    PAT_BLACK7  = 3'd7
  } pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ARG = 2'd1,
    ST_RESP     = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } colour_t;

  // Expand a colour argument byte: RRRGGGBB, blue LSB replicated to 3 bits.
  function automatic colour_t decode_colour(input logic [7:0] arg);
    colour_t c;
    c.r = arg[7:5];
    c.g = arg[4:2];
    c.b = {arg[1:0], arg[0]};
    return c;
  endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel colouring. Output is registered: one clock of latency
// from i_px/i_py/i_activeArea to o_red/o_grn/o_blu.
module vga_pattern_gen
  import vga_cmd_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [2:0] i_pattern,
  input  logic [8:0] i_colour,
  input  logic       i_activeArea,
  input  logic [9:0] i_px,
  input  logic [9:0] i_py,
  output logic [2:0] o_red,
  output logic [2:0] o_grn,
  output logic [2:0] o_blu
);

  localparam logic [9:0] BAR_W  = 10'(H_ACTIVE / 8);
  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

  pattern_e   pat;
  colour_t    colour;
  colour_t    rgb_d;
  colour_t    rgb_q;
  logic [9:0] bar_idx;
  logic [2:0] bar_sel;
  logic       cell_lit;
  logic       on_border;

  assign pat       = pattern_e'(i_pattern);
  assign colour    = colour_t'(i_colour);
  assign bar_idx   = i_px / BAR_W;
  // Clamp so an out-of-range px still lands on the last bar.
  assign bar_sel   = (bar_idx > 10'd7) ? 3'd7 : bar_idx[2:0];
  // 32x32 cells; the cell containing (0,0) is lit.
  assign cell_lit  = ~(i_px[5] ^ i_py[5]);
  assign on_border = (i_px == 10'd0) || (i_px == X_LAST) ||
                     (i_py == 10'd0) || (i_py == Y_LAST);

  // Select the pixel colour for the current pattern; black outside active area.
  always_comb begin
    rgb_d = '0;
    if (i_activeArea) begin
      case (pat)
        PAT_SOLID:   rgb_d = colour;
        PAT_BARS:    rgb_d = '{r: {3{bar_sel[2]}}, g: {3{bar_sel[1]}}, b: {3{bar_sel[0]}}};
        PAT_CHECKER: rgb_d = cell_lit ? colour : '0;
        PAT_HGRAD:   rgb_d = '{r: i_px[9:7], g: i_px[9:7], b: i_px[9:7]};
        PAT_VGRAD:   rgb_d = '{r: i_py[8:6], g: i_py[8:6], b: i_py[8:6]};
        PAT_BORDER:  rgb_d = on_border ? colour : '0;
        default:     rgb_d = '0;
      endcase
    end
  end

  // Pixel output register.
  always_ff @(posedge i_clk) begin
    if (i_reset) rgb_q <= '0;
    else         rgb_q <= rgb_d;
  end

  assign o_red = rgb_q.r;
  assign o_grn = rgb_q.g;
  assign o_blu = rgb_q.b;

endmodule

// File: rtl/vga_cmd_ctrl.sv
// UART-driven VGA test-pattern controller: two-byte command parser with
// argument timeout, pending/applied settings swapped at frame start, and
// pattern generator instance.
// Build option: define VGA_CMD_ACK_EN to send ACK/NAK bytes over the UART
// transmitter; without it the response state is bypassed and tx outputs are 0.
module vga_cmd_ctrl
  import vga_cmd_pkg::*;
#(
  parameter int CLKS_TIMEOUT = 2500000,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rxStrobe,
  input  logic [7:0] i_rxByte,
  input  logic       i_txActive,
  input  logic       i_activeArea,
  input  logic [9:0] i_px,
  input  logic [9:0] i_py,
  output logic       o_txStart,
  output logic [7:0] o_txByte,
  output logic [2:0] o_red,
  output logic [2:0] o_grn,
  output logic [2:0] o_blu,
  output logic [2:0] o_pattern
);

  localparam int              CNT_W    = (CLKS_TIMEOUT > 2) ? $clog2(CLKS_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_colour_q, op_colour_d;
  pattern_e         pend_pat_q, pend_pat_d;
  colour_t          pend_col_q, pend_col_d;
  pattern_e         app_pat_q;
  colour_t          app_col_q;
  logic             frame_start;

`ifdef VGA_CMD_ACK_EN
  logic [7:0] resp_q, resp_d;
  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_byte_q, tx_byte_d;
`else
  logic       unused_tx_active;
  assign unused_tx_active = i_txActive;
`endif

  assign frame_start = (i_px == 10'd0) && (i_py == 10'd0);

  // Parser next-state: opcode, argument/timeout, response handshake.
  always_comb begin
    // NOTE: every _d signal gets its hold value first, so no branch can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_colour_d = op_colour_q;
    pend_pat_d  = pend_pat_q;
    pend_col_d  = pend_col_q;
`ifdef VGA_CMD_ACK_EN
    resp_d      = resp_q;
    tx_start_d  = 1'b0;
    tx_byte_d   = tx_byte_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_rxStrobe) begin
          if (i_rxByte == OP_PATTERN || i_rxByte == OP_COLOUR) begin
            state_d     = ST_WAIT_ARG;
            op_colour_d = (i_rxByte == OP_COLOUR);
            cnt_d       = '0;
          end else begin
`ifdef VGA_CMD_ACK_EN
            state_d = ST_RESP;
            resp_d  = RSP_NAK;
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end
      ST_WAIT_ARG: begin
        if (i_rxStrobe) begin
          if (op_colour_q) pend_col_d = decode_colour(i_rxByte);
          else             pend_pat_d = pattern_e'(i_rxByte[2:0]);
`ifdef VGA_CMD_ACK_EN
          state_d = ST_RESP;
          resp_d  = RSP_ACK;
`else
          state_d = ST_IDLE;
`endif
        end else if (cnt_q == CNT_LAST) begin
`ifdef VGA_CMD_ACK_EN
          state_d = ST_RESP;
          resp_d  = RSP_NAK;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef VGA_CMD_ACK_EN
      ST_RESP: begin
        // Incoming bytes are ignored here by construction.
        if (!i_txActive) begin
          tx_start_d = 1'b1;
          tx_byte_d  = resp_q;
          state_d    = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Parser registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (i_reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_colour_q <= 1'b0;
      pend_pat_q  <= PAT_SOLID;
      pend_col_q  <= '0;
`ifdef VGA_CMD_ACK_EN
      resp_q      <= 8'h00;
      tx_start_q  <= 1'b0;
      tx_byte_q   <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_colour_q <= op_colour_d;
      pend_pat_q  <= pend_pat_d;
      pend_col_q  <= pend_col_d;
`ifdef VGA_CMD_ACK_EN
      resp_q      <= resp_d;
      tx_start_q  <= tx_start_d;
      tx_byte_q   <= tx_byte_d;
`endif
    end
  end

  // Applied settings follow pending only at frame start; a pending write in
  // the same cycle lands in the next frame because the old value is sampled.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      app_pat_q <= PAT_SOLID;
      app_col_q <= '0;
    end else if (frame_start) begin
      app_pat_q <= pend_pat_q;
      app_col_q <= pend_col_q;
    end
  end

`ifdef VGA_CMD_ACK_EN
  assign o_txStart = tx_start_q;
  assign o_txByte  = tx_byte_q;
`else
  assign o_txStart = 1'b0;
  assign o_txByte  = 8'h00;
`endif

  assign o_pattern = app_pat_q;

  vga_pattern_gen #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE)
  ) u_pattern_gen (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_pattern   (app_pat_q),
    .i_colour    (app_col_q),
    .i_activeArea(i_activeArea),
    .i_px        (i_px),
    .i_py        (i_py),
    .o_red       (o_red),
    .o_grn       (o_grn),
    .o_blu       (o_blu)
  );

endmodule

// File: tb/tb_vga_cmd_ctrl.sv
// Directed testbench for vga_cmd_ctrl (timeout shortened to 100 clocks).
// Expectations adapt to whether VGA_CMD_ACK_EN is defined.
`timescale 1ns/1ps
module tb_vga_cmd_ctrl;

`ifdef VGA_CMD_ACK_EN
  localparam int ACK_ON = 1;
`else
  localparam int ACK_ON = 0;
`endif
  localparam logic [7:0] EXP_ACK = (ACK_ON != 0) ? 8'h06 : 8'h00;
  localparam logic [7:0] EXP_NAK = (ACK_ON != 0) ? 8'h15 : 8'h00;

  logic       i_clk = 1'b0;
  logic       i_reset, i_rxStrobe, i_txActive, i_activeArea;
  logic [7:0] i_rxByte;
  logic [9:0] i_px, i_py;
  logic       o_txStart;
  logic [7:0] o_txByte;
  logic [2:0] o_red, o_grn, o_blu, o_pattern;

  int checks = 0;
  int errors = 0;

  vga_cmd_ctrl #(.CLKS_TIMEOUT(100), .H_ACTIVE(640), .V_ACTIVE(480)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rxStrobe(i_rxStrobe), .i_rxByte(i_rxByte),
    .i_txActive(i_txActive), .i_activeArea(i_activeArea), .i_px(i_px), .i_py(i_py),
    .o_txStart(o_txStart), .o_txByte(o_txByte), .o_red(o_red), .o_grn(o_grn),
    .o_blu(o_blu), .o_pattern(o_pattern)
  );

  always #5 i_clk = ~i_clk;

  // Advance one clock; outputs are then read 1 ns after the edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rxStrobe = 1'b1;
    i_rxByte   = b;
    step();
    i_rxStrobe = 1'b0;
  endtask

  // Run n clocks, counting tx pulses and capturing the last pulsed byte.
  task automatic watch(input int n, output int pulses, output logic [7:0] last);
    pulses = 0;
    last   = 8'h00;
    for (int i = 0; i < n; i++) begin
      step();
      if (o_txStart === 1'b1) begin
        pulses++;
        last = o_txByte;
      end
    end
  endtask

  task automatic frame_start();
    i_px = 10'd0;
    i_py = 10'd0;
    step();
    i_px = 10'd5;
    i_py = 10'd5;
  endtask

  task automatic pixel(input int x, input int y, output logic [8:0] rgb);
    i_px = 10'(x);
    i_py = 10'(y);
    step();
    rgb  = {o_red, o_grn, o_blu};
    i_px = 10'd5;
    i_py = 10'd5;
  endtask

  task automatic cmd(input logic [7:0] op, input logic [7:0] arg, input string name);
    int         p;
    logic [7:0] b;
    send_byte(op);
    send_byte(arg);
    watch(6, p, b);
    checks++;
    if (p !== ACK_ON || b !== EXP_ACK) begin
      errors++;
      $display("FAIL %s: pulses=%0d byte=%02h, want pulses=%0d byte=%02h", name, p, b, ACK_ON, EXP_ACK);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (3) step();
    checks++;
    if (o_txStart !== 1'b0 || o_txByte !== 8'h00 || {o_red, o_grn, o_blu} !== 9'd0 || o_pattern !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: start=%b byte=%02h rgb=%03o pat=%0d, want all 0",
               o_txStart, o_txByte, {o_red, o_grn, o_blu}, o_pattern);
    end
    i_reset = 1'b0;
    step();
  endtask

  task automatic test_colour_solid();
    logic [8:0] rgb;
    cmd(8'h43, 8'hE0, "colour_ack");
    cmd(8'h50, 8'h00, "pattern0_ack");
    pixel(100, 100, rgb);
    checks++;
    if (rgb !== 9'o000) begin
      errors++;
      $display("FAIL solid_before_frame: rgb=%03o want 000", rgb);
    end
    frame_start();
    pixel(100, 100, rgb);
    checks++;
    if (rgb !== 9'o700 || o_pattern !== 3'd0) begin
      errors++;
      $display("FAIL solid_red: rgb=%03o pat=%0d want 700 pat=0", rgb, o_pattern);
    end
  endtask

  task automatic test_bars();
    logic [8:0] rgb;
    cmd(8'h50, 8'h01, "bars_ack");
    checks++;
    if (o_pattern !== 3'd0) begin
      errors++;
      $display("FAIL bars_pending_not_applied: pat=%0d want 0", o_pattern);
    end
    frame_start();
    checks++;
    if (o_pattern !== 3'd1) begin
      errors++;
      $display("FAIL bars_applied: pat=%0d want 1", o_pattern);
    end
    pixel(85, 100, rgb);
    checks++;
    if (rgb !== 9'o007) begin
      errors++;
      $display("FAIL bar1_px85: rgb=%03o want 007", rgb);
    end
    pixel(639, 100, rgb);
    checks++;
    if (rgb !== 9'o777) begin
      errors++;
      $display("FAIL bar7_px639: rgb=%03o want 777", rgb);
    end
    i_activeArea = 1'b0;
    pixel(639, 100, rgb);
    i_activeArea = 1'b1;
    checks++;
    if (rgb !== 9'o000) begin
      errors++;
      $display("FAIL blank_inactive: rgb=%03o want 000", rgb);
    end
  endtask

  task automatic test_last_wins_and_same_cycle();
    logic [8:0] rgb;
    int         p;
    logic [7:0] b;
    cmd(8'h50, 8'h02, "p2_ack");
    cmd(8'h50, 8'h03, "p3_ack");
    frame_start();
    pixel(300, 10, rgb);
    checks++;
    if (o_pattern !== 3'd3 || rgb !== 9'o222) begin
      errors++;
      $display("FAIL last_wins_hgrad: pat=%0d rgb=%03o want pat=3 rgb=222", o_pattern, rgb);
    end
    send_byte(8'h50);
    i_px = 10'd0;
    i_py = 10'd0;
    send_byte(8'h04);
    i_px = 10'd5;
    i_py = 10'd5;
    checks++;
    if (o_pattern !== 3'd3) begin
      errors++;
      $display("FAIL same_cycle_old_value: pat=%0d want 3", o_pattern);
    end
    watch(6, p, b);
    frame_start();
    pixel(10, 100, rgb);
    checks++;
    if (o_pattern !== 3'd4 || rgb !== 9'o111) begin
      errors++;
      $display("FAIL next_frame_vgrad: pat=%0d rgb=%03o want pat=4 rgb=111", o_pattern, rgb);
    end
  endtask

  task automatic test_checker_border();
    logic [8:0] rgb;
    logic [8:0] got[4];
    cmd(8'h50, 8'h02, "checker_ack");
    frame_start();
    pixel(10, 10, got[0]);
    pixel(40, 10, got[1]);
    checks++;
    if (got[0] !== 9'o700 || got[1] !== 9'o000) begin
      errors++;
      $display("FAIL checker: (10,10)=%03o (40,10)=%03o want 700 000", got[0], got[1]);
    end
    cmd(8'h50, 8'h05, "border_ack");
    frame_start();
    pixel(0, 50, got[0]);
    pixel(639, 50, got[1]);
    pixel(638, 50, got[2]);
    pixel(50, 479, got[3]);
    pixel(50, 478, rgb);
    checks++;
    if (got[0] !== 9'o700 || got[1] !== 9'o700 || got[2] !== 9'o000 || got[3] !== 9'o700 || rgb !== 9'o000) begin
      errors++;
      $display("FAIL border: %03o %03o %03o %03o %03o want 700 700 000 700 000",
               got[0], got[1], got[2], got[3], rgb);
    end
  endtask

  task automatic test_timeout();
    int         p;
    logic [7:0] b;
    send_byte(8'h50);
`ifdef VGA_CMD_ACK_EN
    begin
      int cyc;
      bit found;
      cyc   = 0;
      found = 1'b0;
      b     = 8'h00;
      while (!found && cyc < 200) begin
        step();
        cyc++;
        if (o_txStart === 1'b1) begin
          found = 1'b1;
          b     = o_txByte;
        end
      end
      checks++;
      if (!found || cyc < 100 || cyc > 102 || b !== 8'h15) begin
        errors++;
        $display("FAIL timeout_nak: found=%0d cycles=%0d byte=%02h want found cycles 100..102 byte 15",
                 found, cyc, b);
      end
      watch(3, p, b);
    end
`else
    watch(110, p, b);
    checks++;
    if (p !== 0) begin
      errors++;
      $display("FAIL timeout_no_pulse: pulses=%0d want 0", p);
    end
`endif
    frame_start();
    checks++;
    if (o_pattern !== 3'd5) begin
      errors++;
      $display("FAIL timeout_pending_kept: pat=%0d want 5", o_pattern);
    end
    cmd(8'h50, 8'h06, "after_timeout_ack");
    frame_start();
    checks++;
    if (o_pattern !== 3'd6) begin
      errors++;
      $display("FAIL idle_after_timeout: pat=%0d want 6", o_pattern);
    end
  endtask

  task automatic test_nak_busy();
    int         p;
    logic [7:0] b;
    i_txActive = 1'b1;
    send_byte(8'h41);
    p = 0;
    for (int i = 0; i < 50; i++) begin
      i_rxStrobe = (i == 10);
      i_rxByte   = 8'h50;
      step();
      if (o_txStart === 1'b1) p++;
    end
    i_rxStrobe = 1'b0;
    checks++;
    if (p !== 0) begin
      errors++;
      $display("FAIL nak_waits_busy: pulses=%0d want 0", p);
    end
    i_txActive = 1'b0;
    watch(5, p, b);
    checks++;
    if (p !== ACK_ON || b !== EXP_NAK) begin
      errors++;
      $display("FAIL nak_single: pulses=%0d byte=%02h want pulses=%0d byte=%02h", p, b, ACK_ON, EXP_NAK);
    end
`ifdef VGA_CMD_ACK_EN
    send_byte(8'h01);
    watch(5, p, b);
    checks++;
    if (p !== 1 || b !== 8'h15) begin
      errors++;
      $display("FAIL dropped_in_resp: pulses=%0d byte=%02h want 1 pulse byte 15", p, b);
    end
`else
    watch(110, p, b);
    checks++;
    if (p !== 0) begin
      errors++;
      $display("FAIL no_tx_build: pulses=%0d want 0", p);
    end
`endif
  endtask

  task automatic test_reset_abort();
    logic [8:0] rgb;
    int         p;
    logic [7:0] b;
    cmd(8'h50, 8'h01, "pre_reset_ack");
    frame_start();
    pixel(639, 10, rgb);
    checks++;
    if (rgb !== 9'o777) begin
      errors++;
      $display("FAIL pre_reset_pixel: rgb=%03o want 777", rgb);
    end
    i_px = 10'd639;
    i_py = 10'd10;
    send_byte(8'h50);
    i_reset = 1'b1;
    step();
    checks++;
    if (o_txStart !== 1'b0 || o_txByte !== 8'h00 || {o_red, o_grn, o_blu} !== 9'd0 || o_pattern !== 3'd0) begin
      errors++;
      $display("FAIL reset_in_wait_arg: start=%b byte=%02h rgb=%03o pat=%0d want all 0",
               o_txStart, o_txByte, {o_red, o_grn, o_blu}, o_pattern);
    end
    i_reset = 1'b0;
    watch(5, p, b);
    checks++;
    if (p !== 0) begin
      errors++;
      $display("FAIL wait_arg_abort_pulse: pulses=%0d want 0", p);
    end
    i_txActive = 1'b1;
    send_byte(8'h41);
    repeat (3) step();
    i_txActive = 1'b0;
    i_reset    = 1'b1;
    step();
    i_reset = 1'b0;
    watch(5, p, b);
    checks++;
    if (p !== 0 || o_txByte !== 8'h00 || {o_red, o_grn, o_blu} !== 9'd0) begin
      errors++;
      $display("FAIL resp_abort: pulses=%0d byte=%02h rgb=%03o want 0 00 000",
               p, o_txByte, {o_red, o_grn, o_blu});
    end
    i_px = 10'd5;
    i_py = 10'd5;
  endtask

  initial begin
    i_reset      = 1'b1;
    i_rxStrobe   = 1'b0;
    i_rxByte     = 8'h00;
    i_txActive   = 1'b0;
    i_activeArea = 1'b1;
    i_px         = 10'd5;
    i_py         = 10'd5;
    test_reset();
    test_colour_solid();
    test_bars();
    test_last_wins_and_same_cycle();
    test_checker_border();
    test_timeout();
    test_nak_busy();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_cmd_ctrl.md
VGA_CMD_CTRL -- requirements
Module: vga_cmd_ctrl

Interface
REQ-001 SHALL have parameter CLKS_TIMEOUT, default 2500000, meaning clocks allowed between command byte and argument byte (100 ms at 25 MHz).
REQ-002 SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-003 SHALL have parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-004 i_clk  input  1  system clock, one pixel per clock.
REQ-005 i_reset  input  1  synchronous, active-high reset.
REQ-006 i_rxStrobe  input  1  one-cycle pulse, i_rxByte valid.
REQ-007 i_rxByte  input  8  received UART byte.
REQ-008 i_txActive  input  1  UART transmitter busy.
REQ-009 i_activeArea, i_px[9:0], i_py[9:0]  input  1/10/10  from sync generator.
REQ-010 o_txStart  output  1  one-cycle pulse, o_txByte valid.
REQ-011 o_txByte  output  8  response byte.
REQ-012 o_red, o_grn, o_blu  output  3 each  pixel colour.
REQ-013 o_pattern  output  3  currently applied pattern.

Function
REQ-014 Parser FSM states SHALL be IDLE, WAIT_ARG, RESP; exact one state per cycle.
REQ-015 IDLE: rx byte 0x50 ('P') or 0x43 ('C') -> WAIT_ARG, latch opcode, clear timeout counter; any other byte -> RESP with NAK (0x15).
REQ-016 WAIT_ARG: rx byte -> write pending register (P: pattern = arg[2:0]; C: colour R=arg[7:5], G=arg[4:2], B={arg[1:0],arg[0]}) -> RESP with ACK (0x06).
REQ-017 WAIT_ARG: counter reaching CLKS_TIMEOUT-1 with no byte -> RESP with NAK; pending unchanged.
REQ-018 RESP: first cycle with i_txActive=0 -> pulse o_txStart one cycle, o_txByte held stable from that cycle until next response, -> IDLE.
REQ-019 rx strobes while in RESP SHALL be dropped.
REQ-020 Pending values SHALL copy to applied registers only on the frame-start cycle (i_px==0 and i_py==0); repeated commands before frame start: last wins.
REQ-021 Pending write and frame start in the same cycle: applied registers take the old pending value; new value applies next frame.
REQ-022 Patterns: 0 solid colour; 1 eight vertical bars, bar index = i_px/(H_ACTIVE/8), colour = {index[2]x3, index[1]x3, index[0]x3}; 2 checkerboard of 32x32 cells, lit cells = colour, else black; 3 horizontal gradient, all channels = i_px[9:7]; 4 vertical gradient, all channels = i_py[8:6]; 5 one-pixel border (px 0/H_ACTIVE-1, py 0/V_ACTIVE-1) in colour, else black; 6-7 black.
REQ-023 Pixel outputs SHALL be registered, latency exactly one clock from i_px/i_py/i_activeArea; i_activeArea=0 -> 0 on all channels.
REQ-024 o_pattern SHALL reflect applied, not pending, pattern.

Reset
REQ-025 Reset SHALL force state IDLE, counters 0, pending and applied pattern 0 and colour 0, o_txStart 0, o_txByte 0x00, o_red/o_grn/o_blu 0, o_pattern 0.
REQ-026 Reset mid-command or during RESP SHALL abort with no response pulse.

Configuration
REQ-027 Macro VGA_CMD_ACK_EN defined: ACK/NAK responses per REQ-015..018.
REQ-028 Macro VGA_CMD_ACK_EN undefined: RESP state bypassed (direct return to IDLE), o_txStart tied 0, o_txByte tied 0x00; parsing and timeout unchanged.

Structure
REQ-029 Package vga_cmd_pkg SHALL hold opcode constants (0x50, 0x43), ACK/NAK codes, pattern encodings, FSM state encodings.
REQ-030 Pixel colouring (REQ-022, REQ-023) SHALL be sub-module vga_pattern_gen; parser, timeout and frame-sync apply stay in vga_cmd_ctrl.

Verification
REQ-031 Bytes 0x43,0xE0 then 0x50,0x00; after next frame start, pixel (100,100) -> o_red=7, o_grn=0, o_blu=0, two ACK 0x06 pulses.
REQ-032 0x50,0x01 -> pixel px=85 yields {0,0,7} (bar1), px=639 yields {7,7,7}; o_pattern unchanged until px=0,py=0 cycle.
REQ-033 Byte 0x41 -> single NAK 0x15; with i_txActive held 1 for 50 clocks, o_txStart waits, 0x50 arriving meanwhile dropped.
REQ-034 0x50 then silence, CLKS_TIMEOUT=100 -> NAK after 100 clocks, FSM IDLE, o_pattern unchanged.
REQ-035 i_reset asserted in WAIT_ARG and in RESP -> no o_txStart pulse, all outputs 0 next cycle.
REQ-036 Build without VGA_CMD_ACK_EN, repeat REQ-031 -> identical pixels, o_txStart never asserted.
